// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV32/RV64 IM decode stage: opcodes, op classes,
// the decoded payload record and the immediate extraction helpers.
package rv_decode_pkg;

    localparam int REGW = 5;
    localparam int IMMW = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [3:0] {
        OC_ALU     = 4'd0,
        OC_ALUIMM  = 4'd1,
        OC_LOAD    = 4'd2,
        OC_STORE   = 4'd3,
        OC_BRANCH  = 4'd4,
        OC_JAL     = 4'd5,
        OC_JALR    = 4'd6,
        OC_LUI     = 4'd7,
        OC_AUIPC   = 4'd8,
        OC_MULDIV  = 4'd9,
        OC_ILLEGAL = 4'd10
    } opclass_e;

    // Immediate is always carried at full 64 bits; narrower datapaths take the low XLEN bits,
    // which is still the correct sign extension.
    typedef struct packed {
        logic [REGW-1:0] rd;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [IMMW-1:0] imm;
        opclass_e        opclass;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            wb_en;
        logic            illegal;
    } decoded_t;

    function automatic logic [IMMW-1:0] imm_i(input logic [31:0] i);
        return {{52{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [IMMW-1:0] imm_s(input logic [31:0] i);
        return {{52{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [IMMW-1:0] imm_b(input logic [31:0] i);
        return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [IMMW-1:0] imm_u(input logic [31:0] i);
        return {{32{i[31]}}, i[31:12], 12'b0};
    endfunction

    function automatic logic [IMMW-1:0] imm_j(input logic [31:0] i);
        return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32/RV64 IM instruction cracker: instruction word -> decoded_t.
// XLEN selects RV32 (W-forms, LD/SD/LWU and 6-bit shamts illegal) or RV64;
// M_EXT=0 makes every funct7=0000001 R-type encoding illegal.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int M_EXT = 1
) (
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    localparam bit RV64  = (XLEN == 64);
    localparam bit HAS_M = (M_EXT != 0);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [REGW-1:0] w_rd;
    logic [REGW-1:0] w_rs1;
    logic [REGW-1:0] w_rs2;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign w_rd  = i_instr[11:7];
    assign w_rs1 = i_instr[19:15];
    assign w_rs2 = i_instr[24:20];

    logic     w_legal;
    logic     w_has_rd;
    opclass_e w_cls;

    // Crack opcode/funct fields into indices, immediate, class and legality.
    always_comb begin
        o_dec        = '0;
        o_dec.funct3 = w_f3;
        w_legal      = 1'b0;
        w_has_rd     = 1'b0;
        w_cls        = OC_ILLEGAL;
        case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                w_legal   = 1'b1;
                w_has_rd  = 1'b1;
                o_dec.rd  = w_rd;
                o_dec.imm = imm_u(i_instr);
                w_cls     = (w_opc == OPC_LUI) ? OC_LUI : OC_AUIPC;
            end
            OPC_JAL: begin
                w_legal   = 1'b1;
                w_has_rd  = 1'b1;
                o_dec.rd  = w_rd;
                o_dec.imm = imm_j(i_instr);
                w_cls     = OC_JAL;
            end
            OPC_JALR: begin
                w_legal   = (w_f3 == 3'b000);
                w_has_rd  = 1'b1;
                o_dec.rd  = w_rd;
                o_dec.rs1 = w_rs1;
                o_dec.imm = imm_i(i_instr);
                w_cls     = OC_JALR;
            end
            OPC_BRANCH: begin
                w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                o_dec.rs1 = w_rs1;
                o_dec.rs2 = w_rs2;
                o_dec.imm = imm_b(i_instr);
                w_cls     = OC_BRANCH;
            end
            OPC_LOAD: begin
                w_has_rd  = 1'b1;
                o_dec.rd  = w_rd;
                o_dec.rs1 = w_rs1;
                o_dec.imm = imm_i(i_instr);
                w_cls     = OC_LOAD;
                case (w_f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = RV64;
                    default:                                w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                o_dec.rs1 = w_rs1;
                o_dec.rs2 = w_rs2;
                o_dec.imm = imm_s(i_instr);
                w_cls     = OC_STORE;
                case (w_f3)
                    3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                    3'b011:                 w_legal = RV64;
                    default:                w_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                w_has_rd  = 1'b1;
                o_dec.rd  = w_rd;
                o_dec.rs1 = w_rs1;
                w_cls     = OC_ALUIMM;
                o_dec.imm = imm_i(i_instr);
                w_legal   = 1'b1;
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    // Shift-immediate: shamt width follows XLEN, upper bits select SRL/SRA
                    o_dec.imm = RV64 ? {58'b0, i_instr[25:20]} : {59'b0, i_instr[24:20]};
                    if (RV64) begin
                        w_legal = (i_instr[31:26] == 6'b000000) ||
                                  ((w_f3 == 3'b101) && (i_instr[31:26] == 6'b010000));
                    end else begin
                        w_legal = (w_f7 == F7_BASE) ||
                                  ((w_f3 == 3'b101) && (w_f7 == F7_ALT));
                    end
                end else begin
                    w_legal = 1'b1;
                end
            end
            OPC_OP_IMM_32: begin
                w_has_rd  = 1'b1;
                o_dec.rd  = w_rd;
                o_dec.rs1 = w_rs1;
                w_cls     = OC_ALUIMM;
                case (w_f3)
                    3'b000: begin
                        o_dec.imm = imm_i(i_instr);
                        w_legal   = RV64;
                    end
                    3'b001: begin
                        o_dec.imm = {59'b0, i_instr[24:20]};
                        w_legal   = RV64 && (w_f7 == F7_BASE);
                    end
                    3'b101: begin
                        o_dec.imm = {59'b0, i_instr[24:20]};
                        w_legal   = RV64 && ((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OP, OPC_OP_32: begin
                w_has_rd     = 1'b1;
                o_dec.rd     = w_rd;
                o_dec.rs1    = w_rs1;
                o_dec.rs2    = w_rs2;
                o_dec.funct7 = w_f7;
                w_cls        = OC_ALU;
                case (w_f7)
                    F7_BASE: w_legal = (w_opc == OPC_OP) ||
                                       (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b101);
                    F7_ALT:  w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                    F7_MUL: begin
                        w_cls   = OC_MULDIV;
                        w_legal = HAS_M && ((w_opc == OPC_OP) ||
                                  (w_f3 == 3'b000) || (w_f3[2] == 1'b1));
                    end
                    default: w_legal = 1'b0;
                endcase
                // Word forms only exist on RV64
                if (w_opc == OPC_OP_32) begin
                    w_legal = w_legal && RV64;
                end else begin
                    w_legal = w_legal;
                end
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        o_dec.opclass = w_legal ? w_cls : OC_ILLEGAL;
        o_dec.illegal = ~w_legal;
        o_dec.wb_en   = w_legal && w_has_rd && (w_rd != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32/RV64 IM decode stage with a 2-entry FIFO between fetch and execute.
// Optional feature: define DECODE_TRACE_EN to print a one-line trace of every popped entry.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int INSTRSZ = 32,
    parameter int REGBITS = 5,
    parameter int M_EXT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTRSZ-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [REGBITS-1:0] out_rd,
    output logic [REGBITS-1:0] out_rs1,
    output logic [REGBITS-1:0] out_rs2,
    output logic [XLEN-1:0]    out_imm,
    output logic [3:0]         out_opclass,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic               out_wb_en,
    output logic               out_illegal
);

    decoded_t w_dec;

    rv_decode_comb #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT)
    ) u_comb (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    decoded_t        r_slot [2];
    logic [XLEN-1:0] r_pc   [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            r_in_ready;

    logic       w_push;
    logic       w_pop;
    logic       w_valid;
    logic [1:0] w_count_nxt;

    assign w_valid = (r_count != 2'd0);
    assign w_push  = in_valid & r_in_ready;
    assign w_pop   = w_valid & out_ready;

    // Next occupancy: flush empties the FIFO and overrides any push/pop this cycle.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointer, count and registered in_ready bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_wr_ptr   <= r_wr_ptr ^ w_push;
            r_rd_ptr   <= r_rd_ptr ^ w_pop;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    // Slot storage: only the write slot is updated, so a held head entry never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_pc[0]   <= '0;
            r_pc[1]   <= '0;
        end else if (w_push && !flush) begin
            r_slot[r_wr_ptr] <= w_dec;
            r_pc[r_wr_ptr]   <= in_pc;
        end
    end

    decoded_t        w_head;
    logic [XLEN-1:0] w_head_pc;

    assign w_head    = r_slot[r_rd_ptr];
    assign w_head_pc = r_pc[r_rd_ptr];

    // Payload is forced to zero whenever the FIFO is empty (including during reset).
    assign in_ready    = r_in_ready;
    assign out_valid   = w_valid;
    assign out_pc      = w_valid ? w_head_pc : '0;
    assign out_rd      = w_valid ? w_head.rd[REGBITS-1:0]  : '0;
    assign out_rs1     = w_valid ? w_head.rs1[REGBITS-1:0] : '0;
    assign out_rs2     = w_valid ? w_head.rs2[REGBITS-1:0] : '0;
    assign out_imm     = w_valid ? w_head.imm[XLEN-1:0]    : '0;
    assign out_opclass = w_valid ? w_head.opclass          : 4'd0;
    assign out_funct3  = w_valid ? w_head.funct3           : 3'd0;
    assign out_funct7  = w_valid ? w_head.funct7           : 7'd0;
    assign out_wb_en   = w_valid ? w_head.wb_en            : 1'b0;
    assign out_illegal = w_valid ? w_head.illegal          : 1'b0;

`ifdef DECODE_TRACE_EN
    function automatic string mnem(input decoded_t d);
        case (d.opclass)
            OC_LUI:    return "LUI";
            OC_AUIPC:  return "AUIPC";
            OC_JAL:    return "JAL";
            OC_JALR:   return "JALR";
            OC_BRANCH: return "BRANCH";
            OC_LOAD:   return "LOAD";
            OC_STORE:  return "STORE";
            OC_MULDIV: return "MULDIV";
            OC_ALUIMM: begin
                case (d.funct3)
                    3'b000:  return "ADDI";
                    3'b001:  return "SLLI";
                    3'b010:  return "SLTI";
                    3'b011:  return "SLTIU";
                    3'b100:  return "XORI";
                    3'b101:  return "SRXI";
                    3'b110:  return "ORI";
                    default: return "ANDI";
                endcase
            end
            OC_ALU: begin
                case (d.funct3)
                    3'b000:  return d.funct7[5] ? "SUB" : "ADD";
                    3'b001:  return "SLL";
                    3'b010:  return "SLT";
                    3'b011:  return "SLTU";
                    3'b100:  return "XOR";
                    3'b101:  return d.funct7[5] ? "SRA" : "SRL";
                    3'b110:  return "OR";
                    default: return "AND";
                endcase
            end
            default:   return "ILLEGAL";
        endcase
    endfunction

    // Trace every entry handed to execute; beats dropped by a flush are not reported.
    always_ff @(posedge clk) begin
        if (rst_n && w_pop && !flush) begin
            $display("pc=%h %s x%0d,x%0d,x%0d,%h", w_head_pc, mnem(w_head),
                     w_head.rd, w_head.rs1, w_head.rs2, w_head.imm[XLEN-1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage. Three instances share the stimulus:
// the default RV64+M build, an RV32 build and an RV64 build without the M extension.
module tb_decode_stage;
    import rv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [63:0] in_pc = 64'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_wb_en, out_illegal;
    logic [63:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_opclass;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;

    logic        a_in_ready, a_out_valid, a_out_wb_en, a_out_illegal;
    logic [31:0] a_out_pc, a_out_imm;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [3:0]  a_out_opclass;
    logic [2:0]  a_out_funct3;
    logic [6:0]  a_out_funct7;

    logic        m_in_ready, m_out_valid, m_out_wb_en, m_out_illegal;
    logic [63:0] m_out_pc, m_out_imm;
    logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
    logic [3:0]  m_out_opclass;
    logic [2:0]  m_out_funct3;
    logic [6:0]  m_out_funct7;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .INSTRSZ(32), .REGBITS(5), .M_EXT(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_opclass(out_opclass), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_wb_en(out_wb_en), .out_illegal(out_illegal));

    decode_stage #(.XLEN(32), .INSTRSZ(32), .REGBITS(5), .M_EXT(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
        .out_imm(a_out_imm), .out_opclass(a_out_opclass), .out_funct3(a_out_funct3),
        .out_funct7(a_out_funct7), .out_wb_en(a_out_wb_en), .out_illegal(a_out_illegal));

    decode_stage #(.XLEN(64), .INSTRSZ(32), .REGBITS(5), .M_EXT(0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_out_pc), .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
        .out_imm(m_out_imm), .out_opclass(m_out_opclass), .out_funct3(m_out_funct3),
        .out_funct7(m_out_funct7), .out_wb_en(m_out_wb_en), .out_illegal(m_out_illegal));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle with execute stalled.
    task automatic load_one(input logic [31:0] instr, input logic [63:0] pc);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        tick();
        in_valid  = 1'b0;
    endtask

    // Pop the head entry.
    task automatic drain_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", in_ready); n_fail++; end
        n_tests++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); n_fail++; end
        n_tests++; if (out_pc !== 64'd0 || out_imm !== 64'd0) begin $display("FAIL reset_payload: pc %h imm %h want 0", out_pc, out_imm); n_fail++; end
        n_tests++; if (out_wb_en !== 1'b0 || out_illegal !== 1'b0) begin $display("FAIL reset_flags: wb %b ill %b want 0", out_wb_en, out_illegal); n_fail++; end
    endtask

    task automatic test_addi();
        load_one(32'hFFF00093, 64'h1000);
        n_tests++; if (out_valid !== 1'b1) begin $display("FAIL addi_valid: got %b want 1", out_valid); n_fail++; end
        n_tests++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0 || out_rs2 !== 5'd0) begin $display("FAIL addi_regs: got %0d,%0d,%0d want 1,0,0", out_rd, out_rs1, out_rs2); n_fail++; end
        n_tests++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin $display("FAIL addi_imm: got %h want ffffffffffffffff", out_imm); n_fail++; end
        n_tests++; if (out_opclass !== OC_ALUIMM) begin $display("FAIL addi_class: got %0d want %0d", out_opclass, OC_ALUIMM); n_fail++; end
        n_tests++; if (out_wb_en !== 1'b1 || out_illegal !== 1'b0) begin $display("FAIL addi_flags: wb %b ill %b want 1 0", out_wb_en, out_illegal); n_fail++; end
        n_tests++; if (out_pc !== 64'h1000) begin $display("FAIL addi_pc: got %h want 1000", out_pc); n_fail++; end
        n_tests++; if (a_out_imm !== 32'hFFFF_FFFF) begin $display("FAIL addi_imm32: got %h want ffffffff", a_out_imm); n_fail++; end
        drain_one();
        n_tests++; if (out_valid !== 1'b0) begin $display("FAIL addi_drain: got %b want 0", out_valid); n_fail++; end
    endtask

    task automatic test_branch_lui();
        load_one(32'hFE208EE3, 64'h2000);
        n_tests++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd0) begin $display("FAIL beq_regs: got rs1 %0d rs2 %0d rd %0d want 1 2 0", out_rs1, out_rs2, out_rd); n_fail++; end
        n_tests++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin $display("FAIL beq_imm: got %h want fffffffffffffffc", out_imm); n_fail++; end
        n_tests++; if (out_opclass !== OC_BRANCH || out_wb_en !== 1'b0) begin $display("FAIL beq_class: got %0d wb %b want %0d 0", out_opclass, out_wb_en, OC_BRANCH); n_fail++; end
        load_one(32'h800002B7, 64'h2004);
        n_tests++; if (in_ready !== 1'b0) begin $display("FAIL full_in_ready: got %b want 0", in_ready); n_fail++; end
        n_tests++; if (out_pc !== 64'h2000) begin $display("FAIL beq_held: got %h want 2000", out_pc); n_fail++; end
        drain_one();
        n_tests++; if (out_rd !== 5'd5 || out_imm !== 64'hFFFF_FFFF_8000_0000) begin $display("FAIL lui_fields: got rd %0d imm %h want 5 ffffffff80000000", out_rd, out_imm); n_fail++; end
        n_tests++; if (out_opclass !== OC_LUI || out_wb_en !== 1'b1) begin $display("FAIL lui_class: got %0d wb %b want %0d 1", out_opclass, out_wb_en, OC_LUI); n_fail++; end
        drain_one();
        n_tests++; if (out_valid !== 1'b0) begin $display("FAIL lui_drain: got %b want 0", out_valid); n_fail++; end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093; in_pc = 64'h100; tick();
        n_tests++; if (in_ready !== 1'b1) begin $display("FAIL b2b_ready_a: got %b want 1", in_ready); n_fail++; end
        in_instr  = 32'h002081B3; in_pc = 64'h104; tick();
        n_tests++; if (in_ready !== 1'b0) begin $display("FAIL b2b_ready_b: got %b want 0", in_ready); n_fail++; end
        in_instr  = 32'h800002B7; in_pc = 64'h108; tick();
        n_tests++; if (in_ready !== 1'b0 || out_pc !== 64'h100) begin $display("FAIL b2b_hold: ready %b pc %h want 0 100", in_ready, out_pc); n_fail++; end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_pc !== 64'h104 || out_opclass !== OC_ALU) begin $display("FAIL b2b_b: pc %h class %0d want 104 %0d", out_pc, out_opclass, OC_ALU); n_fail++; end
        tick();
        n_tests++; if (out_pc !== 64'h108 || out_opclass !== OC_LUI) begin $display("FAIL b2b_c: pc %h class %0d want 108 %0d", out_pc, out_opclass, OC_LUI); n_fail++; end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin $display("FAIL b2b_empty: got %b want 0", out_valid); n_fail++; end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        load_one(32'h00000000, 64'h300);
        n_tests++; if (out_illegal !== 1'b1 || out_wb_en !== 1'b0 || out_opclass !== OC_ILLEGAL) begin $display("FAIL zero_illegal: ill %b wb %b class %0d want 1 0 %0d", out_illegal, out_wb_en, out_opclass, OC_ILLEGAL); n_fail++; end
        drain_one();
        load_one(32'h002081BB, 64'h304);
        n_tests++; if (out_illegal !== 1'b0 || out_wb_en !== 1'b1 || out_rd !== 5'd3) begin $display("FAIL addw_rv64: ill %b wb %b rd %0d want 0 1 3", out_illegal, out_wb_en, out_rd); n_fail++; end
        n_tests++; if (a_out_illegal !== 1'b1 || a_out_wb_en !== 1'b0) begin $display("FAIL addw_rv32: ill %b wb %b want 1 0", a_out_illegal, a_out_wb_en); n_fail++; end
        drain_one();
        load_one(32'h022081B3, 64'h308);
        n_tests++; if (out_opclass !== OC_MULDIV || out_illegal !== 1'b0 || out_funct7 !== 7'b0000001) begin $display("FAIL mul_m: class %0d ill %b f7 %b want %0d 0 0000001", out_opclass, out_illegal, out_funct7, OC_MULDIV); n_fail++; end
        n_tests++; if (m_out_illegal !== 1'b1 || m_out_wb_en !== 1'b0) begin $display("FAIL mul_nom: ill %b wb %b want 1 0", m_out_illegal, m_out_wb_en); n_fail++; end
        drain_one();
        load_one(32'h02109093, 64'h30C);
        n_tests++; if (out_illegal !== 1'b0 || out_imm !== 64'd33 || out_funct7 !== 7'd0) begin $display("FAIL slli33_rv64: ill %b imm %h f7 %b want 0 21 0", out_illegal, out_imm, out_funct7); n_fail++; end
        n_tests++; if (a_out_illegal !== 1'b1) begin $display("FAIL slli33_rv32: got %b want 1", a_out_illegal); n_fail++; end
        drain_one();
        load_one(32'h4010D093, 64'h310);
        n_tests++; if (out_illegal !== 1'b0 || out_imm !== 64'd1) begin $display("FAIL srai_ok: ill %b imm %h want 0 1", out_illegal, out_imm); n_fail++; end
        drain_one();
        load_one(32'h8010D093, 64'h314);
        n_tests++; if (out_illegal !== 1'b1 || out_wb_en !== 1'b0) begin $display("FAIL srai_bad: ill %b wb %b want 1 0", out_illegal, out_wb_en); n_fail++; end
        drain_one();
    endtask

    task automatic test_flush();
        load_one(32'hFFF00093, 64'h400);
        load_one(32'h002081B3, 64'h404);
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin $display("FAIL flush_pre: ready %b valid %b want 0 1", in_ready, out_valid); n_fail++; end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h800002B7;
        in_pc    = 64'h408;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL flush_post: valid %b ready %b want 0 1", out_valid, in_ready); n_fail++; end
        tick();
        n_tests++; if (out_valid !== 1'b0 || out_pc !== 64'd0) begin $display("FAIL flush_survivor: valid %b pc %h want 0 0", out_valid, out_pc); n_fail++; end
    endtask

    task automatic test_async_reset();
        load_one(32'hFFF00093, 64'h500);
        n_tests++; if (out_valid !== 1'b1) begin $display("FAIL arst_pre: got %b want 1", out_valid); n_fail++; end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin $display("FAIL arst_valid: got %b want 0", out_valid); n_fail++; end
        n_tests++; if (out_pc !== 64'd0 || out_imm !== 64'd0 || out_rd !== 5'd0 || out_wb_en !== 1'b0 || out_opclass !== 4'd0) begin $display("FAIL arst_payload: pc %h imm %h rd %0d wb %b class %0d want all 0", out_pc, out_imm, out_rd, out_wb_en, out_opclass); n_fail++; end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL arst_release: ready %b valid %b want 1 0", in_ready, out_valid); n_fail++; end
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_addi();
        test_branch_lui();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
